// File: rtl/rca_wb_unit.sv
// rtl/rca_wb_unit.sv - RCA grid writeback stage with per-port result buffers
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   res_valid/res_data/res_ready  normal-path result from grid
//   fb_res_valid/fb_res_data/
//   fb_res_ready                  feedback-path result from grid
//   wb_id_in, wb_fb_instr         head ID and feedback flag from issue ID FIFO
//   fifo_populated                issue ID FIFO non-empty
//   clear_fifos                   accelerator switch, flushes both buffers
//   wb_committing                 head committed this cycle (pops ID FIFO)
//   wb_done/wb_id/wb_rd/wb_ack    writeback handshake to Taiga
//   stall_cycles                  saturating count of wb_done & ~wb_ack cycles
module rca_wb_unit #(
    parameter int XLEN      = 32,
    parameter int ID_WIDTH  = 3,
    parameter int BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                res_valid,
    input  logic [XLEN-1:0]     res_data,
    output logic                res_ready,
    input  logic                fb_res_valid,
    input  logic [XLEN-1:0]     fb_res_data,
    output logic                fb_res_ready,
    input  logic [ID_WIDTH-1:0] wb_id_in,
    input  logic                wb_fb_instr,
    input  logic                fifo_populated,
    input  logic                clear_fifos,
    output logic                wb_committing,
    output logic                wb_done,
    output logic [ID_WIDTH-1:0] wb_id,
    output logic [XLEN-1:0]     wb_rd,
    input  logic                wb_ack,
    output logic [15:0]         stall_cycles
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;

    logic [XLEN-1:0] n_mem [BUF_DEPTH];
    logic [XLEN-1:0] f_mem [BUF_DEPTH];
    logic [PW-1:0]   n_wr, n_rd, f_wr, f_rd;

    logic n_empty, n_full, f_empty, f_full;
    logic n_push, f_push, n_pop, f_pop;
    logic sel_empty;
    logic [XLEN-1:0] sel_head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign n_empty = (n_wr == n_rd);
    assign f_empty = (f_wr == f_rd);
    assign n_full  = (n_wr[AW] != n_rd[AW]) && (n_wr[AW-1:0] == n_rd[AW-1:0]);
    assign f_full  = (f_wr[AW] != f_rd[AW]) && (f_wr[AW-1:0] == f_rd[AW-1:0]);

    assign res_ready    = ~n_full;
    assign fb_res_ready = ~f_full;

    // Pushes coincident with a clear are dropped along with the flushed contents.
    assign n_push = res_valid & res_ready & ~clear_fifos;
    assign f_push = fb_res_valid & fb_res_ready & ~clear_fifos;

    assign sel_empty = wb_fb_instr ? f_empty : n_empty;
    assign sel_head  = wb_fb_instr ? f_mem[f_rd[AW-1:0]] : n_mem[n_rd[AW-1:0]];

    assign wb_done       = fifo_populated & ~sel_empty & ~clear_fifos;
    assign wb_rd         = sel_empty ? '0 : sel_head;
    assign wb_id         = wb_id_in;
    assign wb_committing = wb_done & wb_ack;

    // Only the buffer matching the head instruction's path is popped.
    assign n_pop = wb_committing & ~wb_fb_instr;
    assign f_pop = wb_committing & wb_fb_instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_wr <= '0;
            n_rd <= '0;
            f_wr <= '0;
            f_rd <= '0;
        end else if (clear_fifos) begin
            n_wr <= '0;
            n_rd <= '0;
            f_wr <= '0;
            f_rd <= '0;
        end else begin
            if (n_push) n_wr <= n_wr + 1'b1;
            if (n_pop)  n_rd <= n_rd + 1'b1;
            if (f_push) f_wr <= f_wr + 1'b1;
            if (f_pop)  f_rd <= f_rd + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (n_push) n_mem[n_wr[AW-1:0]] <= res_data;
        if (f_push) f_mem[f_wr[AW-1:0]] <= fb_res_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (wb_done && !wb_ack && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_rca_wb_unit.sv
// tb/tb_rca_wb_unit.sv - self-checking bench for rca_wb_unit
module tb_rca_wb_unit;

    localparam int XLEN = 32;
    localparam int IDW  = 3;
    localparam int BUFD = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            res_valid, fb_res_valid;
    logic [XLEN-1:0] res_data, fb_res_data;
    logic            res_ready, fb_res_ready;
    logic [IDW-1:0]  wb_id_in;
    logic            wb_fb_instr, fifo_populated, clear_fifos;
    logic            wb_committing, wb_done, wb_ack;
    logic [IDW-1:0]  wb_id;
    logic [XLEN-1:0] wb_rd;
    logic [15:0]     stall_cycles;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    rca_wb_unit #(.XLEN(XLEN), .ID_WIDTH(IDW), .BUF_DEPTH(BUFD)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .fb_res_valid(fb_res_valid), .fb_res_data(fb_res_data), .fb_res_ready(fb_res_ready),
        .wb_id_in(wb_id_in), .wb_fb_instr(wb_fb_instr), .fifo_populated(fifo_populated),
        .clear_fifos(clear_fifos), .wb_committing(wb_committing), .wb_done(wb_done),
        .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each port is a bounded queue of results, stall is an int.
    logic [XLEN-1:0] nq[$];
    logic [XLEN-1:0] fq[$];
    int  m_stall;
    int  nsz, fsz;
    bit  m_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            nq.delete();
            fq.delete();
            m_stall = 0;
        end else begin
            nsz = nq.size();
            fsz = fq.size();
            m_done = fifo_populated && (wb_fb_instr ? (fsz > 0) : (nsz > 0)) && !clear_fifos;
            if (m_done && !wb_ack && m_stall < 65535) m_stall++;
            if (clear_fifos) begin
                chk("clear_with_buffers_empty", nsz + fsz, 0);
                nq.delete();
                fq.delete();
            end else begin
                if (m_done && wb_ack) begin
                    if (wb_fb_instr) void'(fq.pop_front());
                    else             void'(nq.pop_front());
                end
                if (res_valid && nsz < BUFD)    nq.push_back(res_data);
                if (fb_res_valid && fsz < BUFD) fq.push_back(fb_res_data);
            end
        end
    end

    logic            e_done;
    logic [XLEN-1:0] e_rd;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (wb_fb_instr) begin
                e_done = fifo_populated && fq.size() > 0 && !clear_fifos;
                e_rd   = (fq.size() > 0) ? fq[0] : '0;
            end else begin
                e_done = fifo_populated && nq.size() > 0 && !clear_fifos;
                e_rd   = (nq.size() > 0) ? nq[0] : '0;
            end
            chk("m_wb_done", {31'd0, wb_done}, {31'd0, e_done});
            chk("m_wb_rd", wb_rd, e_rd);
            chk("m_wb_id", {29'd0, wb_id}, {29'd0, wb_id_in});
            chk("m_wb_committing", {31'd0, wb_committing}, {31'd0, e_done & wb_ack});
            chk("m_res_ready", {31'd0, res_ready}, {31'd0, nq.size() < BUFD});
            chk("m_fb_res_ready", {31'd0, fb_res_ready}, {31'd0, fq.size() < BUFD});
            chk("m_stall_cycles", {16'd0, stall_cycles}, m_stall);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        res_valid = 0; res_data = '0; fb_res_valid = 0; fb_res_data = '0;
        wb_id_in = '0; wb_fb_instr = 0; fifo_populated = 0; clear_fifos = 0; wb_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        tick(); tick();
        rst = 1;
        tick();
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        cmp_en = 1'b1;
        do_reset();

        // reset state
        chk("rst_res_ready", {31'd0, res_ready}, 1);
        chk("rst_fb_res_ready", {31'd0, fb_res_ready}, 1);
        chk("rst_wb_done", {31'd0, wb_done}, 0);
        chk("rst_stall", {16'd0, stall_cycles}, 0);
        chk("rst_wb_rd", wb_rd, 0);

        // single result
        fifo_populated = 1; wb_id_in = 3'd3; wb_fb_instr = 0;
        res_valid = 1; res_data = 32'h1234;
        tick();
        res_valid = 0;
        #1;
        chk("single_done", {31'd0, wb_done}, 1);
        chk("single_rd", wb_rd, 32'h1234);
        chk("single_id", {29'd0, wb_id}, 3);
        wb_ack = 1;
        #1;
        chk("single_commit", {31'd0, wb_committing}, 1);
        tick();
        wb_ack = 0;
        #1;
        chk("single_empty_done", {31'd0, wb_done}, 0);
        chk("single_empty_rd", wb_rd, 0);
        chk("single_stall", {16'd0, stall_cycles}, 0);

        // backpressure
        do_reset();
        fifo_populated = 1; wb_id_in = 3'd1; wb_fb_instr = 0; wb_ack = 0;
        res_valid = 1; res_data = 32'hA;
        tick();
        res_data = 32'hB;
        tick();
        res_valid = 0;
        chk("bp_ready_full", {31'd0, res_ready}, 0);
        repeat (4) tick();
        chk("bp_stall5", {16'd0, stall_cycles}, 5);
        wb_ack = 1;
        #1;
        chk("bp_first_rd", wb_rd, 32'hA);
        chk("bp_first_commit", {31'd0, wb_committing}, 1);
        tick();
        chk("bp_second_rd", wb_rd, 32'hB);
        tick();
        wb_ack = 0;
        #1;
        chk("bp_drained", {31'd0, wb_done}, 0);
        chk("bp_stall_hold", {16'd0, stall_cycles}, 5);

        // mixed paths
        do_reset();
        fifo_populated = 1; wb_fb_instr = 1; wb_id_in = 3'd5;
        res_valid = 1; res_data = 32'h11;
        tick();
        res_valid = 0;
        #1;
        chk("mix_wait_done", {31'd0, wb_done}, 0);
        fb_res_valid = 1; fb_res_data = 32'h22;
        tick();
        fb_res_valid = 0;
        #1;
        chk("mix_fb_rd", wb_rd, 32'h22);
        chk("mix_fb_done", {31'd0, wb_done}, 1);
        wb_ack = 1;
        tick();
        wb_ack = 0; wb_fb_instr = 0; wb_id_in = 3'd6;
        #1;
        chk("mix_normal_rd", wb_rd, 32'h11);
        wb_ack = 1;
        tick();
        wb_ack = 0;

        // clear coincident with a push
        fifo_populated = 0; clear_fifos = 1; res_valid = 1; res_data = 32'h55;
        #1;
        chk("clr_done", {31'd0, wb_done}, 0);
        tick();
        clear_fifos = 0; res_valid = 0; fifo_populated = 1; wb_fb_instr = 0;
        #1;
        chk("clr_discard_done", {31'd0, wb_done}, 0);
        chk("clr_ready", {31'd0, res_ready}, 1);

        // async reset mid-operation
        wb_ack = 0; res_valid = 1; res_data = 32'h77;
        tick();
        res_data = 32'h78;
        tick();
        res_valid = 0;
        #1;
        rst = 0;
        #1;
        chk("arst_ready", {31'd0, res_ready}, 1);
        chk("arst_done", {31'd0, wb_done}, 0);
        chk("arst_stall", {16'd0, stall_cycles}, 0);
        tick();
        rst = 1;
        tick();

        // saturation
        fifo_populated = 1; wb_fb_instr = 0; wb_ack = 0;
        res_valid = 1; res_data = 32'h99;
        tick();
        res_valid = 0;
        repeat (70000) tick();
        chk("sat_stall", {16'd0, stall_cycles}, 32'hFFFF);
        wb_ack = 1;
        tick();
        wb_ack = 0;
        #1;
        chk("sat_drained", {31'd0, wb_done}, 0);
        chk("sat_hold", {16'd0, stall_cycles}, 32'hFFFF);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_wb_unit.md
Name: rca_wb_unit

Overview:
- Writeback stage directly downstream of the RCA grid and its issue controller.
- Buffers results from the grid's normal output port and its feedback output port, one 2-entry buffer per port.
- Pairs the head result with the instruction ID and feedback flag supplied by the issue controller's ID FIFO, presents it to Taiga writeback, and generates wb_committing, which pops that ID FIFO.
- Also keeps a saturating stall counter for performance monitoring.

Parameters:
- XLEN, 32, result data width.
- ID_WIDTH, 3, width of instruction ID; matches id_t.
- BUF_DEPTH, 2, entries per result buffer; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- res_valid  in  1  normal-path result valid from grid
- res_data  in  XLEN  normal-path result
- res_ready  out  1  normal-path buffer not full
- fb_res_valid  in  1  feedback-path result valid from grid
- fb_res_data  in  XLEN  feedback-path result
- fb_res_ready  out  1  feedback buffer not full
- wb_id_in  in  ID_WIDTH  head ID from issue controller
- wb_fb_instr  in  1  head instruction is a feedback-use instruction
- fifo_populated  in  1  issue controller ID FIFO non-empty
- clear_fifos  in  1  accelerator switch; flush result buffers
- wb_committing  out  1  head committed this cycle; pops ID FIFO
- wb_done  out  1  writeback request to Taiga
- wb_id  out  ID_WIDTH  ID of presented result
- wb_rd  out  XLEN  presented result data
- wb_ack  in  1  Taiga accepts writeback
- stall_cycles  out  16  saturating count of cycles with wb_done & ~wb_ack

Behaviour:
- Reset (rst=0, async):
  - Both buffers empty; read/write pointers = 0.
  - stall_cycles = 0.
  - Outputs: wb_done=0, wb_committing=0, res_ready=1, fb_res_ready=1.
  - wb_rd and wb_id follow the combinational path below: wb_rd = 0 while the selected buffer is empty; wb_id = wb_id_in.
  - A reset mid-transfer discards all buffered results.
- Buffers:
  - Circular, with pointers of log2(BUF_DEPTH)+1 bits; full when the MSBs differ and the LSBs are equal.
  - Push on res_valid & res_ready (or fb_res_valid & fb_res_ready).
  - A push while full cannot occur because ready=0; valid asserted while ready=0 is held by the grid.
  - Simultaneous push and pop on a full buffer: res_ready is 0, so only the pop occurs.
  - Simultaneous push and pop on a non-full buffer: both take effect; occupancy is unchanged.
- Selection and output:
  - sel = wb_fb_instr ? feedback buffer : normal buffer.
  - wb_done = fifo_populated & sel_nonempty & ~clear_fifos (combinational; zero added latency from buffer to writeback).
  - wb_rd = head of sel buffer, or 0 if it is empty.
  - wb_id = wb_id_in.
  - wb_committing = wb_done & wb_ack; pops the sel buffer in the same cycle.
  - A result in the non-selected buffer waits; it is never written back out of order.
- Ordering: the grid returns results in issue order per port. The issue controller guarantees the ID FIFO order matches the combined order.
- Latency: a result pushed at cycle N is visible on wb_done/wb_rd at N+1 when it is the head and its ID is at the FIFO head.
- clear_fifos:
  - Both buffers are flushed on the next edge by setting pointers equal.
  - A push in the same cycle as clear is discarded.
  - wb_done is forced 0 during the clear cycle.
  - clear only arrives with the ID FIFO empty. A clear with either buffer non-empty is a protocol error; the bench flags it with an assertion, and the RTL still flushes.
- fifo_populated=0 with buffered data: hold the data, wb_done=0 (stray result awaiting ID).
- stall_cycles: increments each cycle wb_done=1 & wb_ack=0; saturates at 16'hFFFF; cleared only by reset.

Test Plan:
- Single result: reset; fifo_populated=1, wb_id_in=3, wb_fb_instr=0; push res_data=0x1234 at cycle 0. Required: wb_done=1, wb_rd=0x1234, wb_id=3 at cycle 1; wb_ack=1 gives wb_committing=1 and normal buffer empty at cycle 2.
- Backpressure: push 2 results with wb_ack=0 held 5 cycles. Required: res_ready=0 after the 2nd push; stall_cycles=5; ack twice commits 0xA then 0xB in order.
- Mixed paths: ID head fb=1 while normal buffer holds 0x11 and feedback buffer is empty. Required: wb_done=0. Push fb_res_data=0x22: wb_rd=0x22 next cycle, and 0x11 stays buffered.
- Clear: both buffers empty; clear_fifos=1 coincident with res_valid (0x55). Required: res_data discarded, wb_done=0, buffer empty next cycle.
- Async reset mid-operation: 2 entries buffered, drop rst between edges. Required: res_ready=1, wb_done=0, stall_cycles=0 immediately, before the next clock edge.
- Saturation: force 70000 stall cycles. Required: stall_cycles=0xFFFF with no wrap.
